// File: rtl/scan_mux_if.sv
// scan_mux_if: bus bundle for the scan multiplexer.
// master drives data_in/sel/auto; slave (the mux) drives q/chan/chan_en/tick.
interface scan_mux_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic                      auto;
    logic [WIDTH-1:0]          q;
    logic [SEL_W-1:0]          chan;
    logic [CHANNELS-1:0]       chan_en;
    logic                      tick;

    modport master (
        output data_in, sel, auto,
        input  q, chan, chan_en, tick
    );

    modport slave (
        input  data_in, sel, auto,
        output q, chan, chan_en, tick
    );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel W-bit mux, manual select or auto round-robin scan.
// Ports: clk, reset (sync, active-high), bus (scan_mux_if.slave):
//   data_in/sel/auto in; q/chan/chan_en/tick registered out.
// Macro SCAN_MUX_BLANK_EN: blank chan_en on the auto-scan advance cycle.
module scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DIV      = 16
) (
    input logic       clk,
    input logic       reset,
    scan_mux_if.slave bus
);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [SEL_W-1:0]    chan_q, chan_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic [CHANNELS-1:0] chan_en_q, chan_en_d;
    logic                tick_q, tick_d;

    always_comb begin
        pre_d     = pre_q;
        chan_d    = chan_q;
        tick_d    = 1'b0;
        q_d       = '0;
        chan_en_d = '0;

        if (!bus.auto) begin
            pre_d  = '0;
            chan_d = bus.sel;
        end else if (pre_q == PRE_W'(DIV - 1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // >= also wraps an out-of-range index left by manual mode
            if ({1'b0, chan_q} >= (SEL_W + 1)'(CHANNELS - 1)) begin
                chan_d = '0;
            end else begin
                chan_d = chan_q + SEL_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        // out-of-range index matches no channel: q=0, no enable
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_d == SEL_W'(k)) begin
                q_d          = bus.data_in[k*WIDTH +: WIDTH];
                chan_en_d[k] = 1'b1;
            end
        end

`ifdef SCAN_MUX_BLANK_EN
        // break-before-make on every scan advance
        if (tick_d) begin
            chan_en_d = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            chan_q    <= '0;
            q_q       <= '0;
            chan_en_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            chan_q    <= chan_d;
            q_q       <= q_d;
            chan_en_q <= chan_en_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.chan    = chan_q;
    assign bus.chan_en = chan_en_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed checks of scan_mux (DIV=4 and DIV=1 instances).
// Data pattern 16'hD3A5: ch0=5 ch1=A ch2=3 ch3=D.
module tb_scan_mux;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef SCAN_MUX_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic [3:0] q_tab  [4] = '{4'h5, 4'hA, 4'h3, 4'hD};
    logic [3:0] en_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    scan_mux_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) b0 ();
    scan_mux_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) b1 ();

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b0.auto = 1'b1;
        b0.sel = 2'd2;
        b0.data_in = 16'hD3A5;
        b1.auto = 1'b1;
        b1.sel = 2'd0;
        b1.data_in = 16'hD3A5;
        repeat (3) cyc();
        n_chk++;
        if (b0.q !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_q: got %h want 0", b0.q);
        end
        n_chk++;
        if (b0.chan !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_chan: got %0d want 0", b0.chan);
        end
        n_chk++;
        if (b0.chan_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_chan_en: got %b want 0000", b0.chan_en);
        end
        n_chk++;
        if (b0.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b want 0", b0.tick);
        end
        n_chk++;
        if (b1.tick !== 1'b0 || b1.chan_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_div1: got tick=%b en=%b want 0 0000",
                     b1.tick, b1.chan_en);
        end
    endtask

    task automatic test_manual();
        reset = 1'b0;
        b0.auto = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b0.sel = 2'(k);
            cyc();
            n_chk++;
            if (b0.q !== q_tab[k] || b0.chan !== 2'(k) ||
                b0.chan_en !== en_tab[k] || b0.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_sel%0d: got q=%h chan=%0d en=%b tick=%b want q=%h chan=%0d en=%b tick=0",
                         k, b0.q, b0.chan, b0.chan_en, b0.tick,
                         q_tab[k], k, en_tab[k]);
            end
        end
        b0.sel = 2'd1;
        b0.data_in = 16'hD375;
        cyc();
        n_chk++;
        if (b0.q !== 4'h7) begin
            n_fail++;
            $display("FAIL manual_data_track: got %h want 7", b0.q);
        end
        b0.data_in = 16'hD3A5;
        cyc();
        n_chk++;
        if (b0.q !== 4'hA) begin
            n_fail++;
            $display("FAIL manual_data_restore: got %h want A", b0.q);
        end
    endtask

    task automatic test_auto_scan();
        int ticks;
        logic [1:0] c;
        logic [3:0] en;
        logic       t;
        reset = 1'b1;
        b0.auto = 1'b1;
        cyc();
        reset = 1'b0;
        ticks = 0;
        for (int e = 1; e <= 16; e++) begin
            cyc();
            c  = 2'((e / 4) % 4);
            t  = (e % 4 == 0);
            en = (BLANK && t) ? 4'b0000 : en_tab[c];
            if (b0.tick === 1'b1) ticks++;
            n_chk++;
            if (b0.chan !== c || b0.q !== q_tab[c] ||
                b0.tick !== t || b0.chan_en !== en) begin
                n_fail++;
                $display("FAIL auto_edge%0d: got chan=%0d q=%h tick=%b en=%b want chan=%0d q=%h tick=%b en=%b",
                         e, b0.chan, b0.q, b0.tick, b0.chan_en,
                         c, q_tab[c], t, en);
            end
        end
        n_chk++;
        if (ticks != 4) begin
            n_fail++;
            $display("FAIL auto_tick_count: got %0d want 4", ticks);
        end
        repeat (9) cyc();
        n_chk++;
        if (b0.chan !== 2'd2) begin
            n_fail++;
            $display("FAIL auto_midscan_chan: got %0d want 2", b0.chan);
        end
        reset = 1'b1;
        cyc();
        n_chk++;
        if (b0.q !== 4'h0 || b0.chan !== 2'd0 ||
            b0.chan_en !== 4'b0000 || b0.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_reset: got q=%h chan=%0d en=%b tick=%b want 0 0 0000 0",
                     b0.q, b0.chan, b0.chan_en, b0.tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_mode_switch();
        logic [3:0] en;
        reset = 1'b1;
        b0.auto = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (8) cyc();
        n_chk++;
        if (b0.chan !== 2'd2) begin
            n_fail++;
            $display("FAIL switch_pre_chan: got %0d want 2", b0.chan);
        end
        b0.auto = 1'b0;
        b0.sel = 2'd3;
        cyc();
        n_chk++;
        if (b0.chan !== 2'd3 || b0.q !== 4'hD || b0.tick !== 1'b0 ||
            b0.chan_en !== 4'b1000) begin
            n_fail++;
            $display("FAIL switch_to_manual: got chan=%0d q=%h tick=%b en=%b want 3 D 0 1000",
                     b0.chan, b0.q, b0.tick, b0.chan_en);
        end
        b0.auto = 1'b1;
        b0.sel = 2'd0;
        for (int e = 1; e <= 3; e++) begin
            cyc();
            n_chk++;
            if (b0.chan !== 2'd3 || b0.q !== 4'hD || b0.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL switch_hold%0d: got chan=%0d q=%h tick=%b want 3 D 0",
                         e, b0.chan, b0.q, b0.tick);
            end
        end
        cyc();
        en = BLANK ? 4'b0000 : 4'b0001;
        n_chk++;
        if (b0.chan !== 2'd0 || b0.q !== 4'h5 || b0.tick !== 1'b1 ||
            b0.chan_en !== en) begin
            n_fail++;
            $display("FAIL switch_wrap: got chan=%0d q=%h tick=%b en=%b want 0 5 1 %b",
                     b0.chan, b0.q, b0.tick, b0.chan_en, en);
        end
    endtask

    task automatic test_div1();
        logic [1:0] c;
        logic [3:0] en;
        reset = 1'b1;
        b1.auto = 1'b1;
        cyc();
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            c  = 2'(e % 4);
            en = BLANK ? 4'b0000 : en_tab[c];
            n_chk++;
            if (b1.chan !== c || b1.q !== q_tab[c] ||
                b1.tick !== 1'b1 || b1.chan_en !== en) begin
                n_fail++;
                $display("FAIL div1_edge%0d: got chan=%0d q=%h tick=%b en=%b want chan=%0d q=%h tick=1 en=%b",
                         e, b1.chan, b1.q, b1.tick, b1.chan_en,
                         c, q_tab[c], en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_scan();
        test_mode_switch();
        test_div1();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
